// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel, K-bit arbitrating mux with a registered valid/ready
// output stage and packet lock (a winning channel keeps the output until its
// last beat). Default arbitration is fixed priority, lowest index wins.
// Optional build macro: MUX_ARB_RR_EN switches IDLE arbitration to
// round-robin and adds the rr_ptr register.
//
// Handshake: a beat moves on channel i when in_valid[i] && in_ready[i];
// a beat leaves the output when out_valid && out_ready. Producers hold
// in_data/in_last stable while in_valid=1 and in_ready=0. The output stage
// accepts a new beat whenever it is empty or being drained this cycle.
module mux_arb_n #(
  parameter int K = 8,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*K-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic [K-1:0]     out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [K-1:0]    out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_grant_q, out_grant_d;

  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic            win_last;
  logic [K-1:0]    win_data;
  logic            load_ok;
  logic            xfer;

`ifdef MUX_ARB_RR_EN
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  // Winner selection: owner while locked, otherwise arbitrate over in_valid.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    if (state_q == LOCK) begin
      win_idx = owner_q;
      win_vld = in_valid[owner_q];
    end else begin
`ifdef MUX_ARB_RR_EN
      // Walk from the farthest offset down so the nearest valid channel at
      // or after rr_ptr is the last (and therefore final) assignment.
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[(int'(rr_ptr_q) + i) % N]) begin
          win_idx = IW'((int'(rr_ptr_q) + i) % N);
          win_vld = 1'b1;
        end
      end
`else
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          win_idx = IW'(i);
          win_vld = 1'b1;
        end
      end
`endif
    end
  end

  assign win_last = in_last[win_idx];
  assign win_data = in_data[int'(win_idx) * K +: K];
  assign load_ok  = !out_valid_q || out_ready;
  // Reset blocks any transfer so nothing is accepted while it is asserted.
  assign xfer     = !rst && load_ok && win_vld;
  assign in_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;

  // Next-state for the lock FSM, output stage and round-robin pointer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    out_grant_d = out_grant_q;
`ifdef MUX_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    if (xfer) begin
      out_data_d  = win_data;
      out_last_d  = win_last;
      out_valid_d = 1'b1;
      out_grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (xfer && !win_last) begin
          state_d = LOCK;
          owner_d = win_idx;
        end
      end
      LOCK: begin
        if (xfer && win_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MUX_ARB_RR_EN
    // Only packet-closing beats advance the pointer; in LOCK win_idx is owner.
    if (xfer && win_last) begin
      rr_ptr_d = IW'((int'(win_idx) + 1) % N);
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_grant_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      out_grant_q <= out_grant_d;
    end
  end

`ifdef MUX_ARB_RR_EN
  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign out_grant = out_grant_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n (N=4, K=8). Directed scenarios plus a random
// single-beat phase; expected output beats are queued when stimulus is
// driven and compared when the consumer takes them.
module tb_mux_arb_n;

  localparam int K = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*K-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [K-1:0]   out_data;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_grant;

  logic [N+K:0]   exp_q[$];
  int             n_vec = 0;
  int             n_err = 0;

  mux_arb_n #(.K(K), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grant (out_grant)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l);
    in_valid = v;
    in_last  = l;
  endtask

  task automatic set_data(input int ch, input logic [K-1:0] d);
    in_data[ch*K +: K] = d;
  endtask

  task automatic expect_beat(input logic [K-1:0] d, input logic l, input logic [N-1:0] g);
    exp_q.push_back({g, l, d});
  endtask

  // scoreboard: a beat is consumed when out_valid && out_ready before an edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        logic [N+K:0] e;
        e = exp_q.pop_front();
        check("beat_data", 32'(out_data), 32'(e[K-1:0]));
        check("beat_last", 32'(out_last), 32'(e[K]));
        check("beat_grant", 32'(out_grant), 32'(e[N+K:K+1]));
      end
    end
  end

  initial begin
    logic [N-1:0] mask;
    logic [N-1:0] w;
    logic [K-1:0] d;
    logic [N-1:0] rr_seq [5];
    int           widx;
    int           rr_m;

    // reset with every channel requesting
    rst = 1'b1;
    out_ready = 1'b1;
    in_data = '0;
    for (int c = 0; c < N; c++) set_data(c, 8'hC0 + 8'(c));
    drive(4'b1111, 4'b1111);
    repeat (2) tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_grant", 32'(out_grant), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'h1);
    expect_beat(8'hC0, 1'b1, 4'b0001);
    tick();
    drive(4'b0000, 4'b0000);

    // fixed priority, two single-beat packets back to back
    set_data(1, 8'h11);
    set_data(3, 8'h33);
    drive(4'b1010, 4'b1010);
    @(negedge clk);
    check("prio_ready_ch1", 32'(in_ready), 32'b0010);
    expect_beat(8'h11, 1'b1, 4'b0010);
    tick();
    drive(4'b1000, 4'b1000);
    @(negedge clk);
    check("prio_ready_ch3", 32'(in_ready), 32'b1000);
    check("prio_valid_1", 32'(out_valid), 1);
    expect_beat(8'h33, 1'b1, 4'b1000);
    tick();
    drive(4'b0000, 4'b0000);
    @(negedge clk);
    check("prio_no_bubble", 32'(out_valid), 1);
    tick();

    // packet lock: ch2 three beats, ch0 joins after the first
    set_data(2, 8'hA0);
    drive(4'b0100, 4'b0000);
    @(negedge clk);
    check("lock_ready_a0", 32'(in_ready), 32'b0100);
    expect_beat(8'hA0, 1'b0, 4'b0100);
    tick();
    set_data(0, 8'h05);
    set_data(2, 8'hA1);
    drive(4'b0101, 4'b0001);
    @(negedge clk);
    check("lock_ready_a1", 32'(in_ready), 32'b0100);
    check("lock_state", 32'(dut.state_q), 1);
    expect_beat(8'hA1, 1'b0, 4'b0100);
    tick();
    set_data(2, 8'hA2);
    drive(4'b0101, 4'b0101);
    @(negedge clk);
    check("lock_ready_a2", 32'(in_ready), 32'b0100);
    expect_beat(8'hA2, 1'b1, 4'b0100);
    tick();
    drive(4'b0001, 4'b0001);
    @(negedge clk);
    check("lock_release_ch0", 32'(in_ready), 32'b0001);
    expect_beat(8'h05, 1'b1, 4'b0001);
    tick();

    // backpressure: hold beat 0x05 for five cycles while ch1 waits
    out_ready = 1'b0;
    set_data(1, 8'h77);
    drive(4'b0010, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'h05);
      check("bp_last", 32'(out_last), 1);
      check("bp_grant", 32'(out_grant), 32'b0001);
      check("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'b0010);
    expect_beat(8'h77, 1'b1, 4'b0010);
    tick();
    drive(4'b0000, 4'b0000);
    @(negedge clk);
    check("bp_next_beat", 32'(out_valid), 1);
    tick();

    // reset mid-packet: ch1 locked after its first beat; that beat is dropped
    set_data(1, 8'hB0);
    drive(4'b0010, 4'b0000);
    @(negedge clk);
    check("mid_ready_b0", 32'(in_ready), 32'b0010);
    tick();
    rst = 1'b1;
    set_data(1, 8'hB1);
    set_data(0, 8'h0A);
    drive(4'b0011, 4'b0001);
    @(negedge clk);
    check("mid_locked", 32'(dut.state_q), 1);
    check("mid_rst_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_state_idle", 32'(dut.state_q), 0);
    check("mid_ch0_granted", 32'(in_ready), 32'b0001);
    expect_beat(8'h0A, 1'b1, 4'b0001);
    tick();
    drive(4'b0000, 4'b0000);
    tick();

    // random single-beat traffic at full throughput
    rr_m = 1;
    for (int i = 0; i < 24; i++) begin
      mask = 4'($urandom_range(1, 15));
      for (int c = 0; c < N; c++) set_data(c, 8'($urandom_range(0, 255)));
      drive(mask, 4'b1111);
`ifdef MUX_ARB_RR_EN
      widx = 0;
      for (int j = 0; j < N; j++) begin
        if (mask[(rr_m + j) % N]) begin
          widx = (rr_m + j) % N;
          break;
        end
      end
      w = 4'b0001 << widx;
      rr_m = (widx + 1) % N;
`else
      w = mask & (~mask + 4'b0001);
      widx = 0;
      for (int j = 0; j < N; j++) if (w[j]) widx = j;
`endif
      d = in_data[widx*K +: K];
      @(negedge clk);
      check("rand_ready", 32'(in_ready), 32'(w));
      expect_beat(d, 1'b1, w);
      tick();
    end
    drive(4'b0000, 4'b0000);
    tick();

`ifdef MUX_ARB_RR_EN
    // round-robin rotation from a freshly reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_seq[0] = 4'b0001;
    rr_seq[1] = 4'b0010;
    rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000;
    rr_seq[4] = 4'b0001;
    for (int c = 0; c < N; c++) set_data(c, 8'hD0 + 8'(c));
    drive(4'b1111, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_grant_seq", 32'(in_ready), 32'(rr_seq[i]));
      widx = 0;
      for (int j = 0; j < N; j++) if (rr_seq[i][j]) widx = j;
      expect_beat(8'hD0 + 8'(widx), 1'b1, rr_seq[i]);
      tick();
    end
    drive(4'b0000, 4'b0000);
`endif

    // drain and finish
    repeat (3) tick();
    check("drain_queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised successor of the team's 4:1 one-hot priority mux: N channels, K-bit data, registered output with valid/ready handshake.
- Arbitration is fixed-priority, lowest index wins, matching the existing mux's priority order. Optional round-robin mode.
- Packet lock: once a channel wins, it keeps the output until its `last` beat.
- Sits between multiple producer stages (counters, datapaths) and a single shared consumer.

Parameters:
- K, 8, data width per channel (>=1)
- N, 4, channel count (>=2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  N*K  channel i occupies bits [i*K +: K]
- in_valid  input  N  per-channel valid
- in_last  input  N  per-channel end-of-packet flag, qualified by in_valid
- in_ready  output  N  per-channel ready; one-hot or zero
- out_data  output  K  registered selected data
- out_last  output  1  registered last flag of the selected beat
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready
- out_grant  output  N  registered one-hot index of the channel that produced the current out_data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; it wins over every other event.
- Reset values: out_valid=0, out_data=0, out_last=0, out_grant=0, state=IDLE, owner=0, rr_ptr=0.
- Output stage may load when `load_ok = !out_valid || out_ready` (combinational).
- in_ready is combinational:
  - in_ready[w] = load_ok && winner valid; all other bits 0.
  - in_ready is 0 for every channel when load_ok=0.
- A transfer on channel i is `in_valid[i] && in_ready[i]`.
- On a transfer, next cycle: out_data = channel data, out_last = in_last[i], out_grant = one-hot(i), out_valid=1. Latency is 1 cycle.
- If out_ready=1 and no transfer, out_valid goes to 0; out_data, out_last and out_grant hold their values.
- With out_valid=1 and out_ready=0, all outputs hold stable.
- State machine:
  - IDLE: winner = lowest-index set bit of in_valid. On a transfer with in_last=0, go to LOCK with owner=winner. On a transfer with in_last=1, stay in IDLE.
  - LOCK: winner = owner only. Other channels get in_ready=0 even if valid. If the owner is not valid, no transfer and out_valid drains. On an owner transfer with in_last=1, go to IDLE.
- in_valid=0 for all channels: no transfer, in_ready=0.
- Back-to-back transfers at full throughput: when out_ready is held at 1, one beat per cycle.
- Reset mid-packet: LOCK is abandoned, state returns to IDLE, and the in-flight output beat is dropped.
- Behaviour is undefined if in_data or in_last change while in_valid=1 and in_ready=0 (producer rule: hold stable).

Optional Feature:
- MUX_ARB_RR_EN
- Defined: IDLE arbitration is round-robin.
  - Winner = first valid channel at or after rr_ptr, wrapping N-1 to 0.
  - On every transfer that returns to or stays in IDLE (last=1), rr_ptr = (winner+1) mod N.
  - rr_ptr is not updated in LOCK except on the closing last beat, where it becomes (owner+1) mod N.
- Undefined: fixed lowest-index priority, and the rr_ptr register is not instantiated.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_grant=0, in_ready=0; first cycle after release, in_ready=4'b0001.
- Fixed priority, N=4, K=8: in_valid=4'b1010 with ch1=0x11 and ch3=0x33, both last=1, out_ready=1 -> out_data=0x11 with grant 4'b0010, then 0x33 with grant 4'b1000. Two cycles, no bubbles.
- Packet lock: ch2 sends 3 beats 0xA0, 0xA1, 0xA2 (last on the third) while ch0 is valid throughout -> in_ready[0]=0 until the cycle after 0xA2 transfers; then ch0 is granted.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles -> out_data, out_last and out_grant stable, in_ready=0; out_ready=1 -> the next beat loads the following cycle.
- Reset mid-packet: ch1 in LOCK after beat 1 of 3, assert rst for 1 cycle -> out_valid=0, state IDLE; ch0 valid is granted immediately after release.
- With MUX_ARB_RR_EN: all 4 channels continuously valid with last=1, out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001.
